// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
// Optional timeout abort is enabled with the ARB_TIMEOUT_EN macro.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF         = 32;
    localparam int unsigned DATA_W_DEF         = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_MEM = 2'd1,
        ST_BUSY_IF  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Busy-cycle counter for the arbiter timeout abort (built only with ARB_TIMEOUT_EN).
module arb_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // High in the busy cycle whose missing ack makes the count reach LIMIT.
    assign tc_c = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory bus between IF fetches and MEM loads/stores.
// MEM wins ties; define ARB_TIMEOUT_EN to abort accesses that never see an ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_in_req_en_l,
    input  logic [ADDR_W-1:0]   if_in_addr_l,
    input  logic                mem_in_req_en_l,
    input  logic                mem_in_we_l,
    input  logic [ADDR_W-1:0]   mem_in_addr_l,
    input  logic [DATA_W-1:0]   mem_in_wdata_l,
    input  logic [DATA_W/8-1:0] mem_in_be_l,
    input  logic                bus_in_ack_l,
    input  logic [DATA_W-1:0]   bus_in_rdata_l,
    output logic                arb_out_req_w,
    output logic                arb_out_we_w,
    output logic [ADDR_W-1:0]   arb_out_addr_w,
    output logic [DATA_W-1:0]   arb_out_wdata_w,
    output logic [DATA_W/8-1:0] arb_out_be_w,
    output logic [DATA_W-1:0]   arb_out_if_rdata_w,
    output logic                arb_out_if_valid_w,
    output logic [DATA_W-1:0]   arb_out_mem_rdata_w,
    output logic                arb_out_mem_valid_w,
    output logic                arb_out_stall_if_en_w,
    output logic                arb_out_stall_mem_en_w,
    output logic                arb_out_err_w
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              mem_elig;
    logic              if_elig;
    logic              grant_mem;
    logic              grant_if;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_valid_q;
    logic              mem_valid_q;
    logic              err_q;

    // A request is still the completed one while its valid is high, so mask it.
    assign mem_elig = mem_in_req_en_l & ~mem_valid_q;
    assign if_elig  = if_in_req_en_l & ~if_valid_q;
    assign busy     = (state != ST_IDLE);
    assign done     = busy & (bus_in_ack_l | timeout);

`ifdef ARB_TIMEOUT_EN
    logic tc;

    arb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (grant_mem | grant_if),
        .enable (busy & ~bus_in_ack_l),
        .tc_c   (tc)
    );

    // An ack in the terminal cycle takes precedence over the abort.
    assign timeout = busy & ~bus_in_ack_l & tc;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // After completion the other requester is served directly, without an idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mem_elig) begin
                    state_nxt = ST_BUSY_MEM;
                end else if (if_elig) begin
                    state_nxt = ST_BUSY_IF;
                end
            end
            ST_BUSY_MEM: if (done) state_nxt = if_elig ? ST_BUSY_IF : ST_IDLE;
            ST_BUSY_IF:  if (done) state_nxt = mem_elig ? ST_BUSY_MEM : ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_mem     = 1'b0;
        grant_if      = 1'b0;
        arb_out_req_w = busy;
        if (state_nxt == ST_BUSY_MEM && state != ST_BUSY_MEM) grant_mem = 1'b1;
        if (state_nxt == ST_BUSY_IF && state != ST_BUSY_IF)   grant_if  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (grant_mem) begin
                addr_q  <= mem_in_addr_l;
                we_q    <= mem_in_we_l;
                wdata_q <= mem_in_wdata_l;
                be_q    <= mem_in_be_l;
            end else if (grant_if) begin
                // Fetches always read a full word.
                addr_q  <= if_in_addr_l;
                we_q    <= 1'b0;
                wdata_q <= '0;
                be_q    <= '1;
            end
            mem_valid_q <= (state == ST_BUSY_MEM) & done;
            if_valid_q  <= (state == ST_BUSY_IF) & done;
            err_q       <= timeout;
            if (state == ST_BUSY_MEM && done) begin
                mem_rdata_q <= (we_q | timeout) ? '0 : bus_in_rdata_l;
            end
            if (state == ST_BUSY_IF && done) begin
                if_rdata_q <= timeout ? '0 : bus_in_rdata_l;
            end
        end
    end

    assign arb_out_we_w           = we_q;
    assign arb_out_addr_w         = addr_q;
    assign arb_out_wdata_w        = wdata_q;
    assign arb_out_be_w           = be_q;
    assign arb_out_if_rdata_w     = if_rdata_q;
    assign arb_out_if_valid_w     = if_valid_q;
    assign arb_out_mem_rdata_w    = mem_rdata_q;
    assign arb_out_mem_valid_w    = mem_valid_q;
    assign arb_out_err_w          = err_q;
    assign arb_out_stall_if_en_w  = if_in_req_en_l & ~if_valid_q;
    assign arb_out_stall_mem_en_w = mem_in_req_en_l & ~mem_valid_q;

endmodule
